// File: rtl/lvds_deser_pkg.sv
// Shared types and default constants for the LVDS deserialiser/word aligner.
package lvds_deser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_VERIFY = 2'd2,
        ST_LOCKED = 2'd3
    } lane_state_e;

    localparam int unsigned             DEF_WORD_W    = 12;
    localparam logic [DEF_WORD_W-1:0]   DEF_TRAIN_PAT = 12'hFC0;
    localparam int unsigned             DEF_LOCK_CNT  = 4;

endpackage

// File: rtl/lvds_lane_align.sv
// One serial lane: MSB-first shift register, word-boundary counter with bit slip,
// and the search/verify/lock state machine that aligns the counter to the training word.
module lvds_lane_align
    import lvds_deser_pkg::*;
#(
    parameter int unsigned         WORD_W    = DEF_WORD_W,
    parameter logic [WORD_W-1:0]   TRAIN_PAT = WORD_W'(DEF_TRAIN_PAT),
    parameter int unsigned         LOCK_CNT  = DEF_LOCK_CNT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              serial_bit,
    input  logic              train_en,
    input  logic              relock,
    output logic [WORD_W-1:0] word,
    output logic              valid,
    output logic              locked,
    output logic              align_err
);

    localparam int unsigned CNT_W = $clog2(WORD_W);
    localparam int unsigned MCH_W = $clog2(LOCK_CNT + 1);

    logic [WORD_W-1:0] sr;
    logic [CNT_W-1:0]  bit_cnt;
    logic              slip_pend;

    lane_state_e       state, state_d;
    logic [MCH_W-1:0]  match_cnt, match_d;
    logic [CNT_W-1:0]  slip_cnt, slips_d;
    logic              err_d;
    logic [WORD_W-1:0] word_d;
    logic              valid_d;
    logic              slip_c;
    logic              boundary_c;
    logic              match_c;

    assign boundary_c = (bit_cnt == CNT_W'(WORD_W - 1));
    assign match_c    = (sr == TRAIN_PAT);

    // A slip freezes the counter for the cycle after the boundary, delaying the next one by a bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr        <= '0;
            bit_cnt   <= '0;
            slip_pend <= 1'b0;
        end else begin
            sr <= {sr[WORD_W-2:0], serial_bit};
            if (slip_pend) begin
                slip_pend <= 1'b0;
            end else begin
                bit_cnt   <= boundary_c ? '0 : bit_cnt + CNT_W'(1);
                slip_pend <= slip_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            match_cnt <= '0;
            slip_cnt  <= '0;
            align_err <= 1'b0;
            word      <= '0;
            valid     <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state     <= state_d;
            match_cnt <= match_d;
            slip_cnt  <= slips_d;
            align_err <= err_d;
            word      <= word_d;
            valid     <= valid_d;
            locked    <= (state_d == ST_LOCKED);
        end
    end

    // Relock wins over any boundary evaluation in the same cycle.
    always_comb begin
        state_d = state;
        match_d = match_cnt;
        slips_d = slip_cnt;
        err_d   = align_err;
        word_d  = word;
        valid_d = 1'b0;
        slip_c  = 1'b0;
        if (relock) begin
            state_d = train_en ? ST_SEARCH : ST_IDLE;
            match_d = '0;
            slips_d = '0;
            err_d   = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (train_en) state_d = ST_SEARCH;
                end
                ST_SEARCH: begin
                    if (!train_en) begin
                        state_d = ST_IDLE;
                    end else if (boundary_c) begin
                        if (match_c) begin
                            state_d = ST_VERIFY;
                            match_d = MCH_W'(1);
                        end else begin
                            slip_c = !slip_pend;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (!train_en) begin
                        state_d = ST_IDLE;
                    end else if (boundary_c) begin
                        if (match_c) begin
                            match_d = match_cnt + MCH_W'(1);
                            if (match_cnt == MCH_W'(LOCK_CNT - 1)) state_d = ST_LOCKED;
                        end else begin
                            state_d = ST_SEARCH;
                            slip_c  = !slip_pend;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (boundary_c) begin
                        word_d  = sr;
                        valid_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (slip_c) begin
                if (slip_cnt == CNT_W'(WORD_W - 1)) begin
                    slips_d = '0;
                    err_d   = 1'b1;
                end else begin
                    slips_d = slip_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/lvds_deser_align.sv
// Multi-lane LVDS deserialiser with per-lane training-word alignment; packs lane words
// onto one bus and reports a registered all-lanes-locked flag.
module lvds_deser_align
    import lvds_deser_pkg::*;
#(
    parameter int unsigned         LANES     = 4,
    parameter int unsigned         WORD_W    = DEF_WORD_W,
    parameter logic [WORD_W-1:0]   TRAIN_PAT = WORD_W'(DEF_TRAIN_PAT),
    parameter int unsigned         LOCK_CNT  = DEF_LOCK_CNT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LANES-1:0]          serial_in,
    input  logic                      train_en,
    input  logic                      relock,
    output logic [LANES*WORD_W-1:0]   data_out,
    output logic [LANES-1:0]          data_valid,
    output logic [LANES-1:0]          lane_locked,
    output logic                      all_locked,
    output logic [LANES-1:0]          align_err
);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        lvds_lane_align #(
            .WORD_W    (WORD_W),
            .TRAIN_PAT (TRAIN_PAT),
            .LOCK_CNT  (LOCK_CNT)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .serial_bit (serial_in[l]),
            .train_en   (train_en),
            .relock     (relock),
            .word       (data_out[l*WORD_W +: WORD_W]),
            .valid      (data_valid[l]),
            .locked     (lane_locked[l]),
            .align_err  (align_err[l])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) all_locked <= 1'b0;
        else        all_locked <= &lane_locked;
    end

endmodule

// File: doc/lvds_deser_align.md
LVDS_DESER_ALIGN -- requirements
Module: lvds_deser_align

Interface
REQ-001 SHALL have parameter LANES, default 4, number of serial lanes.
REQ-002 SHALL have parameter WORD_W, default 12, bits per deserialised word.
REQ-003 SHALL have parameter TRAIN_PAT, default 12'hFC0, WORD_W-bit training word, MSB first.
REQ-004 SHALL have parameter LOCK_CNT, default 4, consecutive pattern matches required for lock.
REQ-005 SHALL have port clk  input  1  bit-rate clock; one bit per lane sampled per rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port serial_in  input  LANES  received LVDS bit per lane.
REQ-008 SHALL have port train_en  input  1  level; enables alignment search on unlocked lanes.
REQ-009 SHALL have port relock  input  1  one-cycle pulse; forces all lanes back to SEARCH.
REQ-010 SHALL have port data_out  output  LANES*WORD_W  aligned words, lane l at bits [l*WORD_W +: WORD_W].
REQ-011 SHALL have port data_valid  output  LANES  per-lane one-cycle word strobe.
REQ-012 SHALL have port lane_locked  output  LANES  per-lane lock status.
REQ-013 SHALL have port all_locked  output  1  AND of lane_locked, registered.
REQ-014 SHALL have port align_err  output  LANES  sticky: full slip sweep without match.

Function
REQ-015 Per lane, a WORD_W-bit shift register SHALL shift left each cycle, serial_in[l] entering at LSB (MSB-first framing).
REQ-016 Per lane, a bit counter 0..WORD_W-1 SHALL increment each cycle and wrap; count WORD_W-1 marks the word boundary.
REQ-017 A slip SHALL hold that lane's bit counter for exactly one cycle, so the next boundary occurs WORD_W+1 cycles later; no slip SHALL be issued while a previous slip is pending.
REQ-018 Per-lane FSM states: IDLE, SEARCH, VERIFY, LOCKED.
REQ-019 IDLE -> SEARCH when train_en=1; SEARCH/VERIFY -> IDLE when train_en=0.
REQ-020 SEARCH at boundary: word==TRAIN_PAT -> VERIFY, match_cnt=1; else slip, slip_cnt+1.
REQ-021 slip_cnt reaching WORD_W SHALL set align_err[l], wrap slip_cnt to 0 and continue searching.
REQ-022 VERIFY at boundary: match -> match_cnt+1, LOCKED when match_cnt reaches LOCK_CNT; mismatch -> SEARCH plus slip.
REQ-023 LOCKED SHALL ignore train_en and content; only relock (or reset) leaves LOCKED, to SEARCH with counters cleared.
REQ-024 relock in any state SHALL clear match_cnt, slip_cnt, align_err and enter SEARCH (IDLE if train_en=0).
REQ-025 In LOCKED, at each boundary, data_out lane word SHALL update and data_valid[l] pulse on the following cycle (latency 1 after last bit sampled); data_out holds otherwise.
REQ-026 data_valid SHALL never assert outside LOCKED; lane_locked[l]=1 exactly in LOCKED.
REQ-027 relock coincident with a boundary SHALL take priority over match/slip evaluation.

Reset
REQ-028 rst_n low SHALL asynchronously clear data_out, data_valid, lane_locked, all_locked, align_err, all counters and shift registers, and set every FSM to IDLE.
REQ-029 Reset release SHALL be synchronous to clk; first counter increment on the first edge after release.

Structure
REQ-030 Package lvds_deser_pkg SHALL hold the FSM state enum and default WORD_W, TRAIN_PAT, LOCK_CNT constants.
REQ-031 Sub-module lvds_lane_align SHALL implement one lane (shift reg, counter, FSM) and be generated LANES times; top holds only all_locked and bus packing.

Verification (LANES=4, WORD_W=12, TRAIN_PAT=12'hFC0, LOCK_CNT=4)
REQ-032 Assert rst_n=0 mid-stream -> all outputs 0 immediately, FSMs IDLE, no data_valid until relock.
REQ-033 Lane 0 repeating 12'hFC0 offset 5 bits, train_en=1 -> exactly 5 slips, lane_locked[0]=1 after 4 matching boundaries, align_err[0]=0.
REQ-034 Lanes offsets 0,3,7,11 -> each lane locks independently; all_locked rises one cycle after the last lane locks.
REQ-035 Lane 2 constant 12'h555 stream -> align_err[2]=1 after 12 slips, lane_locked[2] stays 0, other lanes unaffected.
REQ-036 Locked lane 1 then word 12'h5A3 -> data_out[23:12]=12'h5A3 with data_valid[1] one cycle after last bit, strobes every 12 cycles.
REQ-037 Reset during VERIFY (match_cnt=2), then relock pulse while LOCKED -> counters cleared, lane returns to SEARCH, relocks on training data.
